reg_wb_queue: RTL and testbench

//  Write-side initiator for the 12x8 register file's write port (write/rd_addr/rd_in; rd_addr selects regs 8..11).

---
 rtl/reg_wb_queue.sv | 93 +++++++++
 tb/tb_reg_wb_queue.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/reg_wb_queue.sv
// reg_wb_queue: writeback FIFO that drives the register-file write port
//   and exposes pending/bypass lookup information for decode.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   in_valid/in_ready  writeback request handshake; in_addr/in_data payload
//   flush              drop every queued write
//   hold               write port busy; head is kept and re-presented
//   write/rd_addr/rd_in  register-file write port
//   pending            one bit per writable register with a queued write
//   lookup_addr/hit/data  youngest-entry bypass query
//   count              occupied entries
//   ovf_err            sticky push-while-not-ready error
module reg_wb_queue #(
    parameter int REG_WIDTH = 8,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [REG_WIDTH-1:0]       in_data,
    input  logic                       flush,
    input  logic                       hold,
    output logic                       write,
    output logic [ADDR_W-1:0]          rd_addr,
    output logic [REG_WIDTH-1:0]       rd_in,
    output logic [(1<<ADDR_W)-1:0]     pending,
    input  logic [ADDR_W-1:0]          lookup_addr,
    output logic                       lookup_hit,
    output logic [REG_WIDTH-1:0]       lookup_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf_err
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                 ovf_q, ovf_d;
    logic [ADDR_W-1:0]    addr_q [DEPTH];
    logic [REG_WIDTH-1:0] data_q [DEPTH];
    logic                 push;
    logic [PW-1:0]        slot;

    always_comb begin
        // Forcing the occupancy to zero while in reset makes every derived
        // output idle even before the pointers have been cleared.
        count       = rst_n ? wr_ptr_q - rd_ptr_q : '0;
        in_ready    = rst_n & ~flush & (count != (PW+1)'(DEPTH));
        write       = rst_n & ~flush & ~hold & (count != '0);
        push        = in_valid & in_ready;
        rd_addr     = (count != '0) ? addr_q[rd_ptr_q[PW-1:0]] : '0;
        rd_in       = (count != '0) ? data_q[rd_ptr_q[PW-1:0]] : '0;
        wr_ptr_d    = wr_ptr_q + (PW+1)'(push);
        rd_ptr_d    = flush ? wr_ptr_q : rd_ptr_q + (PW+1)'(write);
        ovf_d       = ovf_q | (in_valid & ~in_ready & rst_n & ~flush);
        ovf_err     = ovf_q;
        pending     = '0;
        lookup_hit  = 1'b0;
        lookup_data = '0;
        slot        = '0;
        // Walk oldest to youngest so a later match overrides an earlier one.
        for (int k = 0; k < DEPTH; k++) begin
            slot = rd_ptr_q[PW-1:0] + PW'(k);
            if ((PW+1)'(k) < count) begin
                pending[addr_q[slot]] = 1'b1;
                if (addr_q[slot] == lookup_addr) begin
                    lookup_hit  = 1'b1;
                    lookup_data = data_q[slot];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q[PW-1:0]] <= in_addr;
            data_q[wr_ptr_q[PW-1:0]] <= in_data;
        end
    end
endmodule

// File: tb/tb_reg_wb_queue.sv
// tb_reg_wb_queue: scoreboard bench for reg_wb_queue
module tb_reg_wb_queue;
    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_ready, flush, hold, write, lookup_hit, ovf_err;
    logic [1:0] in_addr, rd_addr, lookup_addr;
    logic [7:0] in_data, rd_in, lookup_data;
    logic [3:0] pending;
    logic [2:0] count;
    int         checks = 0;
    int         errors = 0;
    logic [9:0] exp_q [$];

    always #5 clk = ~clk;

    reg_wb_queue dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .flush(flush), .hold(hold),
        .write(write), .rd_addr(rd_addr), .rd_in(rd_in), .pending(pending),
        .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
        .count(count), .ovf_err(ovf_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push_req(input logic [1:0] a, input logic [7:0] d, input bit acc);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        if (acc) exp_q.push_back({a, d});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && write === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", rd_addr, rd_in);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({rd_addr, rd_in} !== e) begin
                    errors++;
                    $display("FAIL write_order: got %0h:%0h expected %0h:%0h", rd_addr, rd_in, e[9:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; in_addr = 2'd3; in_data = 8'hFF;
        flush = 1'b0; hold = 1'b0; lookup_addr = 2'd0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_write", write, 0);
            chk("rst_ready", in_ready, 0);
            chk("rst_count", count, 0);
            chk("rst_ovf", ovf_err, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", in_ready, 1);
        chk("count_after_rst", count, 0);

        lookup_addr = 2'd2;
        push_req(2'd2, 8'hA5, 1);
        @(negedge clk);
        chk("single_write", write, 1);
        chk("single_pending", pending, 4'b0100);
        chk("single_hit", lookup_hit, 1);
        chk("single_ldata", lookup_data, 8'hA5);
        @(posedge clk); #1;
        @(negedge clk);
        chk("single_count", count, 0);
        chk("single_idle", write, 0);
        chk("single_nohit", lookup_hit, 0);
        chk("single_nodata", lookup_data, 0);

        hold = 1'b1; lookup_addr = 2'd1;
        push_req(2'd1, 8'h11, 1);
        push_req(2'd3, 8'h22, 1);
        push_req(2'd1, 8'h33, 1);
        push_req(2'd0, 8'h44, 1);
        @(negedge clk);
        chk("full_count", count, 4);
        chk("full_ready", in_ready, 0);
        chk("full_write", write, 0);
        chk("full_ovf0", ovf_err, 0);
        chk("full_hit", lookup_hit, 1);
        chk("full_ldata", lookup_data, 8'h33);
        chk("full_pending", pending, 4'b1011);
        push_req(2'd2, 8'h55, 0);
        @(negedge clk);
        chk("ovf_set", ovf_err, 1);
        chk("ovf_count", count, 4);

        hold = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("drain_count", count, 0);
        chk("drain_pending", pending, 0);
        chk("drain_exp_empty", exp_q.size(), 0);

        hold = 1'b1;
        push_req(2'd2, 8'h01, 1);
        push_req(2'd3, 8'h02, 1);
        hold = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push_req(2'(i), 8'h10 + 8'(i), 1);
            @(negedge clk);
            chk("simul_count", count, 2);
            chk("simul_ready", in_ready, 1);
        end
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("simul_drained", count, 0);
        chk("simul_exp_empty", exp_q.size(), 0);

        hold = 1'b1;
        push_req(2'd0, 8'h51, 1);
        push_req(2'd1, 8'h52, 1);
        push_req(2'd2, 8'h53, 1);
        @(negedge clk);
        chk("flush_pre_count", count, 3);
        hold = 1'b0; flush = 1'b1; in_valid = 1'b1; in_addr = 2'd3; in_data = 8'hEE;
        #1;
        chk("flush_write", write, 0);
        chk("flush_ready", in_ready, 0);
        exp_q.delete();
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_count", count, 0);
        chk("flush_idle", write, 0);
        chk("flush_pending", pending, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("final_count", count, 0);
        chk("final_exp_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
